// File: rtl/serial_sub4_if.sv
// Handshake and operand bundle for serial_sub4.
// SERIAL_SUB_OVF_EN adds the signed-overflow result flag ovf.
interface serial_sub4_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin, input d, bout, busy, done, ovf);
    modport slave  (input start, a, b, bin, output d, bout, busy, done, ovf);
`else
    modport master (output start, a, b, bin, input d, bout, busy, done);
    modport slave  (input start, a, b, bin, output d, bout, busy, done);
`endif
endinterface

// File: rtl/serial_sub4.sv
// Bit-serial subtractor d = a - b - bin, LSB first, start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub4 #(
    parameter int unsigned WIDTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    serial_sub4_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             diff, br_next;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        diff    = sa_q[0] ^ sb_q[0] ^ br_q;
        br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    br_d    = bus.bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = {diff, res_q[WIDTH-1:1]};
                br_d  = br_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    d_d     = {diff, res_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    done_d  = 1'b1;
                    state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    // On the last bit sa_q[0]/sb_q[0] are the original operand sign bits.
                    ovf_d   = (sa_q[0] ^ sb_q[0]) & (diff ^ sa_q[0]);
`endif
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.d    = d_q;
    assign bus.bout = bout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_sub4.sv
// Self-checking bench for serial_sub4: directed cases plus randomized operands vs. an arithmetic model.
`timescale 1ns/1ps
module tb_serial_sub4;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned MOD   = 1 << WIDTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned checks = 0;
    int unsigned failures = 0;

    serial_sub4_if #(.WIDTH(WIDTH)) bus ();

    serial_sub4 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic on the operands as unsigned and as two's complement.
    function automatic void model(input int unsigned a, input int unsigned b, input int unsigned bin,
                                  output logic [31:0] d, output logic [31:0] bout,
                                  output logic [31:0] ovf);
        int full, sa, sb, sr;
        full = int'(a) - int'(b) - int'(bin);
        d    = (full < 0) ? 32'(full + int'(MOD)) : 32'(full);
        bout = (full < 0) ? 32'd1 : 32'd0;
        sa   = (a >= MOD / 2) ? int'(a) - int'(MOD) : int'(a);
        sb   = (b >= MOD / 2) ? int'(b) - int'(MOD) : int'(b);
        sr   = sa - sb - int'(bin);
        ovf  = (sr < -int'(MOD / 2) || sr > int'(MOD / 2) - 1) ? 32'd1 : 32'd0;
    endfunction

    task automatic do_op(input string tag, input int unsigned a, input int unsigned b,
                         input int unsigned bin, input int unsigned exp_d,
                         input int unsigned exp_bout, input bit inject);
        int unsigned cyc;
        int unsigned pulses;
        bit          seen;
        logic [31:0] md, mb, mo;
        logic [WIDTH-1:0] av, bv;
        av = a[WIDTH-1:0];
        bv = b[WIDTH-1:0];
        model(a, b, bin, md, mb, mo);
        @(negedge clk);
        bus.a = av; bus.b = bv; bus.bin = bin[0]; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, ".busy_run"}, 32'(bus.busy), 32'd1);
        check({tag, ".done_early"}, 32'(bus.done), 32'd0);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 4 * WIDTH) begin
            @(negedge clk);
            cyc++;
            if (bus.done === 1'b1) seen = 1'b1;
            else if (inject && cyc == 1) begin
                bus.start = 1'b1; bus.a = 1; bus.b = 1; bus.bin = 1'b0;
            end
        end
        bus.start = 1'b0;
        check({tag, ".latency"}, seen ? 32'(cyc) : 32'd0, 32'(WIDTH));
        check({tag, ".busy_done"}, 32'(bus.busy), 32'd1);
        check({tag, ".d"}, 32'(bus.d), 32'(exp_d));
        check({tag, ".bout"}, 32'(bus.bout), 32'(exp_bout));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, ".ovf"}, 32'(bus.ovf), mo);
`endif
        @(negedge clk);
        check({tag, ".done_fall"}, 32'(bus.done), 32'd0);
        check({tag, ".busy_idle"}, 32'(bus.busy), 32'd0);
        if (inject) begin
            pulses = 0;
            for (int i = 0; i < 2 * int'(WIDTH); i++) begin
                @(negedge clk);
                if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
            end
            check({tag, ".no_requeue"}, 32'(pulses), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] md, mb, mo;
        int unsigned ra, rb, rc, pulses;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;

        #3;
        check("rst.d", 32'(bus.d), 32'd0);
        check("rst.bout", 32'(bus.bout), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("t9m5", 9, 5, 0, 4, 0, 1'b0);
        do_op("t3m5", 3, 5, 0, 14, 1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold.d", 32'(bus.d), 32'd14);
            check("hold.bout", 32'(bus.bout), 32'd1);
        end
        do_op("t0m0b1", 0, 0, 1, 15, 1, 1'b0);
        do_op("t15m15", 15, 15, 0, 0, 0, 1'b0);
        do_op("busy_start", 9, 5, 0, 4, 0, 1'b1);

        // Abort mid-RUN with an asynchronous reset between clock edges.
        @(negedge clk);
        bus.a = 4'd9; bus.b = 4'd5; bus.bin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort.d", 32'(bus.d), 32'd0);
        check("abort.bout", 32'(bus.bout), 32'd0);
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        rst_n = 1'b1;
        repeat (WIDTH + 2) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        check("abort.no_done", 32'(pulses), 32'd0);
        do_op("t6m2", 6, 2, 0, 4, 0, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        do_op("ovf7m15", 7, 15, 0, 8, 1, 1'b0);
        check("ovf7m15.flag", 32'(bus.ovf), 32'd1);
        do_op("ovf8m1", 8, 1, 0, 7, 0, 1'b0);
        check("ovf8m1.flag", 32'(bus.ovf), 32'd1);
        do_op("ovf5m2", 5, 2, 0, 3, 0, 1'b0);
        check("ovf5m2.flag", 32'(bus.ovf), 32'd0);
`endif

        for (int i = 0; i < 40; i++) begin
            ra = $urandom_range(MOD - 1, 0);
            rb = $urandom_range(MOD - 1, 0);
            rc = $urandom_range(1, 0);
            model(ra, rb, rc, md, mb, mo);
            do_op("rand", ra, rb, rc, md, mb, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
